// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_if
//  Brief    : Data-memory req/ack bus between the MA stage and memory.
//  Revision : 1.0
// ============================================================================
interface mem_access_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      mem_req;
    logic                      mem_we;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0]     mem_wdata;
    logic [DATA_WIDTH/8-1:0]   mem_be;
    logic                      mem_ack;
    logic [DATA_WIDTH-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Brief    : MA-stage load/store unit: lane alignment, extension, misalign
//             and bus-timeout detection over a req/ack memory interface.
//  Revision : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    input  logic                   in_is_load_i,
    input  logic                   in_is_store_i,
    input  logic [1:0]             in_size_i,
    input  logic                   in_unsigned_i,
    input  logic [ADDR_WIDTH-1:0]  in_addr_i,
    input  logic [DATA_WIDTH-1:0]  in_wdata_i,
    input  logic [4:0]             in_rd_i,
    input  logic                   in_rd_we_i,
    input  logic                   flush_i,
    output logic                   stall_o,
    mem_access_unit_if.master      mem_bus,
    output logic                   wb_valid_o,
    output logic [4:0]             wb_rd_o,
    output logic                   wb_we_o,
    output logic [DATA_WIDTH-1:0]  wb_data_o,
    output logic                   misalign_o,
    output logic                   timeout_err_o
);
    localparam int         BW            = DATA_WIDTH / 8;
    localparam int         OFFW          = $clog2(BW);
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam logic [7:0] DW8           = 8'(DATA_WIDTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    mem_req_q, mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;
    logic [BW-1:0]           mem_be_q;
    logic                    load_q, unsigned_q, rd_we_q, abort_q;
    logic [1:0]              size_q;
    logic [OFFW-1:0]         off_q;
    logic [4:0]              rd_q;
    logic [7:0]              tmo_cnt_q;
    logic                    wb_valid_q, wb_we_q, misalign_q, timeout_err_q;
    logic [4:0]              wb_rd_q;
    logic [DATA_WIDTH-1:0]   wb_data_q;

    logic                    is_mem, size_ok, aligned, accept, suppress;
    logic [OFFW-1:0]         in_off, align_mask;
    logic [BW-1:0]           be_base, be_new;
    logic [DATA_WIDTH-1:0]   wdata_rep, rshift, lmask, load_data;
    logic [7:0]              nbits;
    logic                    lsign;

    always_comb begin
        is_mem     = in_is_load_i | in_is_store_i;
        in_off     = in_addr_i[OFFW-1:0];
        align_mask = OFFW'((4'd1 << in_size_i) - 4'd1);
        // Double-word accesses only exist on a 64-bit bus; elsewhere they fault as misaligned.
        size_ok    = (in_size_i != 2'd3) || (DATA_WIDTH == 64);
        aligned    = size_ok && ((in_off & align_mask) == '0);
        accept     = (state_q == IDLE) && in_valid_i && is_mem && aligned && !flush_i;
        stall_o    = (state_q == BUSY) || accept;
        suppress   = abort_q || flush_i;

        be_base    = BW'((9'd1 << (4'd1 << in_size_i)) - 9'd1);
        be_new     = be_base << in_off;
        case (in_size_i)
            2'd0:    wdata_rep = {BW{in_wdata_i[7:0]}};
            2'd1:    wdata_rep = {(BW/2){in_wdata_i[15:0]}};
            2'd2:    wdata_rep = {(BW/4){in_wdata_i[31:0]}};
            default: wdata_rep = in_wdata_i;
        endcase

        // Sign bit is the top bit of the mask, isolated as mask ^ (mask >> 1).
        rshift    = mem_bus.mem_rdata >> {off_q, 3'b000};
        nbits     = 8'd8 << size_q;
        lmask     = {DATA_WIDTH{1'b1}} >> (DW8 - nbits);
        lsign     = |(rshift & (lmask ^ (lmask >> 1)));
        load_data = (rshift & lmask) | ((lsign && !unsigned_q) ? ~lmask : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            load_q        <= 1'b0;
            unsigned_q    <= 1'b0;
            rd_we_q       <= 1'b0;
            abort_q       <= 1'b0;
            size_q        <= 2'd0;
            off_q         <= '0;
            rd_q          <= 5'd0;
            tmo_cnt_q     <= 8'd0;
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            misalign_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            wb_rd_q       <= 5'd0;
            wb_data_q     <= '0;
        end else begin
            wb_valid_q    <= 1'b0;
            misalign_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid_i && !flush_i) begin
                        if (!is_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_rd_q    <= in_rd_i;
                            wb_we_q    <= in_rd_we_i;
                            wb_data_q  <= DATA_WIDTH'(in_addr_i);
                        end else if (!aligned) begin
                            wb_valid_q <= 1'b1;
                            misalign_q <= 1'b1;
                            wb_rd_q    <= in_rd_i;
                            wb_we_q    <= 1'b0;
                            wb_data_q  <= '0;
                        end else begin
                            state_q     <= BUSY;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= in_is_store_i;
                            mem_addr_q  <= {in_addr_i[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
                            mem_wdata_q <= wdata_rep;
                            mem_be_q    <= be_new;
                            load_q      <= in_is_load_i;
                            unsigned_q  <= in_unsigned_i;
                            size_q      <= in_size_i;
                            off_q       <= in_off;
                            rd_q        <= in_rd_i;
                            rd_we_q     <= in_rd_we_i;
                            abort_q     <= 1'b0;
                            tmo_cnt_q   <= 8'd0;
                        end
                    end
                end
                BUSY: begin
                    if (mem_bus.mem_ack) begin
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        wb_valid_q <= !suppress;
                        wb_rd_q    <= rd_q;
                        wb_we_q    <= !suppress && load_q && rd_we_q;
                        wb_data_q  <= load_q ? load_data : '0;
                    end else if (tmo_cnt_q + 8'd1 == TIMEOUT_LIMIT) begin
                        state_q       <= IDLE;
                        mem_req_q     <= 1'b0;
                        wb_valid_q    <= !suppress;
                        timeout_err_q <= !suppress;
                        wb_rd_q       <= rd_q;
                        wb_we_q       <= 1'b0;
                        wb_data_q     <= '0;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                        if (flush_i) begin
                            abort_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_bus.mem_req   = mem_req_q;
    assign mem_bus.mem_we    = mem_we_q;
    assign mem_bus.mem_addr  = mem_addr_q;
    assign mem_bus.mem_wdata = mem_wdata_q;
    assign mem_bus.mem_be    = mem_be_q;
    assign wb_valid_o        = wb_valid_q;
    assign wb_rd_o           = wb_rd_q;
    assign wb_we_o           = wb_we_q;
    assign wb_data_o         = wb_data_q;
    assign misalign_o        = misalign_q;
    assign timeout_err_o     = timeout_err_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Brief    : Self-checking bench for mem_access_unit (32-bit bus, timeout 4).
//  Revision : 1.0
// ============================================================================
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_is_load, in_is_store, in_unsigned, in_rd_we, flush;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic [4:0]  in_rd;
    logic        stall, wb_valid, wb_we, misalign, timeout_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int tests = 0;
    int fails = 0;

    int          stall_n, req_n, wb_n, wb_cyc;
    bit          stable;
    logic [31:0] m_addr, m_wdata, w_data;
    logic [3:0]  m_be;
    logic        m_we, w_we, w_mis, w_tmo;
    logic [4:0]  w_rd;

    mem_access_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mem_access_unit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_is_load_i(in_is_load), .in_is_store_i(in_is_store),
        .in_size_i(in_size), .in_unsigned_i(in_unsigned), .in_addr_i(in_addr),
        .in_wdata_i(in_wdata), .in_rd_i(in_rd), .in_rd_we_i(in_rd_we), .flush_i(flush),
        .stall_o(stall), .mem_bus(bus),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_we_o(wb_we), .wb_data_o(wb_data),
        .misalign_o(misalign), .timeout_err_o(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] exp_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [1:0] sz, input logic uns);
        int          off = int'(addr % 4);
        int          nb  = 1 << sz;
        logic [63:0] v, mask;
        v    = 64'(rdata) >> (8 * off);
        mask = (64'd1 << (8 * nb)) - 64'd1;
        v    = v & mask;
        if (!uns && v[8*nb-1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic [1:0] sz);
        logic [7:0] t;
        t = 8'(((1 << (1 << sz)) - 1) << (addr % 4));
        return t[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] r;
        int          nb = 1 << sz;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic bit is_misaligned(input logic [31:0] addr, input logic [1:0] sz);
        return (sz == 2'd3) || ((addr % (1 << sz)) != 0);
    endfunction

    // ---------------- driver / memory responder ----------------
    task automatic idle_inputs();
        in_valid = 0; in_is_load = 0; in_is_store = 0; in_unsigned = 0; in_rd_we = 0;
        flush = 0; in_size = 0; in_addr = 0; in_wdata = 0; in_rd = 0;
        bus.mem_ack = 0; bus.mem_rdata = 0;
    endtask

    task automatic run_op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input logic rdwe, input int wait_n, input bit give_ack,
                          input logic [31:0] rdata, input int flush_at);
        stall_n = 0; req_n = 0; wb_n = 0; wb_cyc = -1; stable = 1;
        m_addr = 0; m_wdata = 0; m_be = 0; m_we = 0;
        w_data = 0; w_we = 0; w_rd = 0; w_mis = 0; w_tmo = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            in_valid = (c == 0); in_is_load = ld; in_is_store = st; in_size = sz;
            in_unsigned = uns; in_addr = addr; in_wdata = wd; in_rd = rd; in_rd_we = rdwe;
            flush = (c == flush_at);
            bus.mem_ack   = give_ack && bus.mem_req && (req_n == wait_n);
            bus.mem_rdata = bus.mem_ack ? rdata : $urandom;
            #1;
            if (stall) stall_n++;
            if (bus.mem_req) begin
                if (req_n == 0) begin
                    m_addr = bus.mem_addr; m_wdata = bus.mem_wdata; m_be = bus.mem_be; m_we = bus.mem_we;
                end else if (bus.mem_addr !== m_addr || bus.mem_wdata !== m_wdata ||
                             bus.mem_be !== m_be || bus.mem_we !== m_we) begin
                    stable = 0;
                end
                req_n++;
            end
            if (wb_valid) begin
                wb_n++; wb_cyc = c; w_data = wb_data; w_we = wb_we; w_rd = wb_rd;
                w_mis = misalign; w_tmo = timeout_err;
            end
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (bus.mem_req !== 1'b0) begin fails++; $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
        tests++; if ({wb_valid, wb_we, misalign, timeout_err} !== 4'b0) begin fails++; $display("FAIL reset_wb_flags: got %b expected 0000", {wb_valid, wb_we, misalign, timeout_err}); end
        tests++; if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata, wb_data, wb_rd} !== '0) begin fails++; $display("FAIL reset_buses: got nonzero bus/wb value expected 0"); end
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_load_word();
        run_op(1, 0, 2'd2, 0, 32'h100, 0, 5'd3, 1, 3, 1, 32'hDEADBEEF, -1);
        tests++; if (m_be !== 4'hF) begin fails++; $display("FAIL lw_be: got %h expected f", m_be); end
        tests++; if (stall_n !== 5) begin fails++; $display("FAIL lw_stall_cycles: got %0d expected 5", stall_n); end
        tests++; if (req_n !== 4) begin fails++; $display("FAIL lw_req_cycles: got %0d expected 4", req_n); end
        tests++; if (wb_cyc !== 5) begin fails++; $display("FAIL lw_latency: got %0d expected 5", wb_cyc); end
        tests++; if (w_data !== 32'hDEADBEEF || w_we !== 1'b1 || w_rd !== 5'd3) begin fails++; $display("FAIL lw_result: got %h we=%b rd=%0d expected deadbeef we=1 rd=3", w_data, w_we, w_rd); end
        tests++; if (m_addr !== 32'h100 || m_we !== 1'b0) begin fails++; $display("FAIL lw_addr: got %h we=%b expected 100 we=0", m_addr, m_we); end
    endtask

    task automatic test_load_byte();
        run_op(1, 0, 2'd0, 0, 32'h103, 0, 5'd4, 1, 0, 1, 32'h80123456, -1);
        tests++; if (w_data !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_signed: got %h expected ffffff80", w_data); end
        tests++; if (m_be !== 4'h8) begin fails++; $display("FAIL lb_be: got %h expected 8", m_be); end
        tests++; if (wb_cyc !== 2) begin fails++; $display("FAIL lb_latency: got %0d expected 2", wb_cyc); end
        run_op(1, 0, 2'd0, 1, 32'h103, 0, 5'd4, 1, 1, 1, 32'h80123456, -1);
        tests++; if (w_data !== 32'h00000080) begin fails++; $display("FAIL lbu_unsigned: got %h expected 00000080", w_data); end
    endtask

    task automatic test_store_half();
        run_op(0, 1, 2'd1, 0, 32'h102, 32'h1234, 5'd5, 1, 1, 1, 0, -1);
        tests++; if (m_addr !== 32'h100) begin fails++; $display("FAIL sh_addr: got %h expected 100", m_addr); end
        tests++; if (m_be !== 4'hC) begin fails++; $display("FAIL sh_be: got %h expected c", m_be); end
        tests++; if (m_wdata !== 32'h12341234) begin fails++; $display("FAIL sh_wdata: got %h expected 12341234", m_wdata); end
        tests++; if (m_we !== 1'b1 || w_we !== 1'b0 || wb_n !== 1) begin fails++; $display("FAIL sh_we: got mem_we=%b wb_we=%b wb_n=%0d expected 1 0 1", m_we, w_we, wb_n); end
        tests++; if (!stable) begin fails++; $display("FAIL sh_bus_stable: got unstable expected stable"); end
    endtask

    task automatic test_misalign();
        run_op(1, 0, 2'd2, 0, 32'h101, 0, 5'd6, 1, 0, 1, 32'h0, -1);
        tests++; if (req_n !== 0 || stall_n !== 0) begin fails++; $display("FAIL misalign_noreq: got req=%0d stall=%0d expected 0 0", req_n, stall_n); end
        tests++; if (wb_cyc !== 1 || w_mis !== 1'b1 || w_we !== 1'b0) begin fails++; $display("FAIL misalign_wb: got cyc=%0d mis=%b we=%b expected 1 1 0", wb_cyc, w_mis, w_we); end
    endtask

    task automatic test_timeout();
        run_op(1, 0, 2'd2, 0, 32'h40, 0, 5'd7, 1, 0, 0, 0, -1);
        tests++; if (req_n !== 4) begin fails++; $display("FAIL timeout_req_cycles: got %0d expected 4", req_n); end
        tests++; if (wb_cyc !== 5 || w_tmo !== 1'b1 || w_we !== 1'b0 || wb_n !== 1) begin fails++; $display("FAIL timeout_wb: got cyc=%0d tmo=%b we=%b n=%0d expected 5 1 0 1", wb_cyc, w_tmo, w_we, wb_n); end
        tests++; if (stall_n !== 5) begin fails++; $display("FAIL timeout_stall: got %0d expected 5", stall_n); end
        @(posedge clk); #1; bus.mem_ack = 1; bus.mem_rdata = 32'h55AA55AA;
        @(posedge clk); #1; bus.mem_ack = 0; #1;
        tests++; if (wb_valid !== 1'b0 || bus.mem_req !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL late_ack_ignored: got wb=%b req=%b stall=%b expected 0 0 0", wb_valid, bus.mem_req, stall); end
    endtask

    task automatic test_flush();
        run_op(1, 0, 2'd2, 0, 32'h200, 0, 5'd8, 1, 0, 1, 32'h1, 0);
        tests++; if (req_n !== 0 || wb_n !== 0) begin fails++; $display("FAIL flush_idle: got req=%0d wb=%0d expected 0 0", req_n, wb_n); end
        run_op(1, 0, 2'd2, 0, 32'h204, 0, 5'd8, 1, 2, 1, 32'h2, 2);
        tests++; if (req_n !== 3 || wb_n !== 0 || stall_n !== 4) begin fails++; $display("FAIL flush_busy: got req=%0d wb=%0d stall=%0d expected 3 0 4", req_n, wb_n, stall_n); end
        run_op(1, 0, 2'd2, 0, 32'h208, 0, 5'd8, 1, 1, 1, 32'h3, 2);
        tests++; if (req_n !== 2 || wb_n !== 0) begin fails++; $display("FAIL flush_with_ack: got req=%0d wb=%0d expected 2 0", req_n, wb_n); end
        run_op(1, 0, 2'd2, 0, 32'h20C, 0, 5'd9, 1, 0, 1, 32'hCAFEF00D, -1);
        tests++; if (wb_n !== 1 || w_data !== 32'hCAFEF00D) begin fails++; $display("FAIL after_flush_load: got n=%0d data=%h expected 1 cafef00d", wb_n, w_data); end
    endtask

    task automatic test_reset_busy();
        int wbs = 0;
        @(posedge clk); #1;
        in_valid = 1; in_is_load = 1; in_size = 2'd2; in_addr = 32'h300; in_rd = 5'd1; in_rd_we = 1;
        @(posedge clk); #1; idle_inputs(); #1;
        tests++; if (bus.mem_req !== 1'b1) begin fails++; $display("FAIL rst_busy_pre: got req=%b expected 1", bus.mem_req); end
        rst = 1;
        @(posedge clk); #1; rst = 0; #1;
        tests++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL rst_busy_drop: got req=%b stall=%b expected 0 0", bus.mem_req, stall); end
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (wb_valid) wbs++; end
        tests++; if (wbs !== 0) begin fails++; $display("FAIL rst_busy_no_wb: got %0d expected 0", wbs); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int          kind  = $urandom_range(0, 2);
            logic [1:0]  sz    = 2'($urandom_range(0, 2));
            logic        uns   = 1'($urandom);
            logic [31:0] addr  = $urandom;
            logic [31:0] wd    = $urandom;
            logic [31:0] rdata = $urandom;
            logic [4:0]  rd    = 5'($urandom);
            logic        rdwe  = 1'($urandom);
            int          wt    = $urandom_range(0, 3);
            logic        ld    = (kind == 1);
            logic        st    = (kind == 2);
            if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << sz) - 32'd1);
            run_op(ld, st, sz, uns, addr, wd, rd, rdwe, wt, 1, rdata, -1);
            if (kind == 0) begin
                tests++; if (wb_n !== 1 || wb_cyc !== 1 || w_data !== addr || w_we !== rdwe || w_rd !== rd || stall_n !== 0) begin fails++; $display("FAIL rnd_alu[%0d]: got n=%0d cyc=%0d data=%h we=%b rd=%0d stall=%0d expected 1 1 %h %b %0d 0", n, wb_n, wb_cyc, w_data, w_we, w_rd, stall_n, addr, rdwe, rd); end
            end else if (is_misaligned(addr, sz)) begin
                tests++; if (req_n !== 0 || wb_n !== 1 || wb_cyc !== 1 || w_mis !== 1'b1 || w_we !== 1'b0) begin fails++; $display("FAIL rnd_misalign[%0d]: got req=%0d n=%0d cyc=%0d mis=%b we=%b expected 0 1 1 1 0", n, req_n, wb_n, wb_cyc, w_mis, w_we); end
            end else begin
                tests++; if (m_addr !== (addr & ~32'd3) || m_be !== exp_be(addr, sz) || m_we !== st || !stable) begin fails++; $display("FAIL rnd_bus[%0d]: got addr=%h be=%h we=%b stable=%b expected %h %h %b 1", n, m_addr, m_be, m_we, stable, addr & ~32'd3, exp_be(addr, sz), st); end
                tests++; if (req_n !== wt + 1 || stall_n !== wt + 2 || wb_n !== 1 || wb_cyc !== wt + 2 || w_mis !== 1'b0 || w_tmo !== 1'b0) begin fails++; $display("FAIL rnd_timing[%0d]: got req=%0d stall=%0d n=%0d cyc=%0d expected %0d %0d 1 %0d", n, req_n, stall_n, wb_n, wb_cyc, wt + 1, wt + 2, wt + 2); end
                if (st) begin
                    tests++; if (m_wdata !== exp_wdata(wd, sz) || w_we !== 1'b0) begin fails++; $display("FAIL rnd_store[%0d]: got wdata=%h we=%b expected %h 0", n, m_wdata, w_we, exp_wdata(wd, sz)); end
                end else begin
                    tests++; if (w_data !== exp_load(rdata, addr, sz, uns) || w_we !== rdwe || w_rd !== rd) begin fails++; $display("FAIL rnd_load[%0d]: got data=%h we=%b rd=%0d expected %h %b %0d", n, w_data, w_we, w_rd, exp_load(rdata, addr, sz, uns), rdwe, rd); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_misalign();
        test_timeout();
        test_flush();
        test_reset_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
